program_counter: RTL and testbench
==================================

PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 SHALL expose parameter WIDTH, default 16: counter and address width in bits.
REQ-002 SHALL expose parameter RESET_ADDR, default 0: value loaded on async reset and on clr.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port in, input, WIDTH: jump target.
REQ-006 SHALL have port load, input, 1: take in on the next edge.
REQ-007 SHALL have port inc, input, 1: advance by one on the next edge.
REQ-008 SHALL have port clr, input, 1: synchronous return to RESET_ADDR.
REQ-009 SHALL have port stall, input, 1: freeze the counter this cycle.
REQ-010 SHALL have port out, output, WIDTH: the registered current address.
REQ-011 SHALL have port halted, output, 1: registered flag, high while the FSM is in HALT.

Function
REQ-012 out SHALL be a pure register output, with no combinational path from any input.
REQ-013 The next-address select SHALL be priority clr > load > inc > hold, a 4-way mux chain feeding the register.
REQ-014 A stall high at an edge SHALL hold out, unless clr is high; clr overrides stall.
REQ-015 The increment SHALL be modulo 2^WIDTH: all-ones + inc gives 0 with no flag.
REQ-016 load SHALL take effect exactly one edge after it is sampled (latency 1); a simultaneous inc is ignored.
REQ-017 With no control asserted, out SHALL hold indefinitely.
REQ-018 The FSM SHALL have states RUN and HALT and SHALL enter RUN on reset.
REQ-019 RUN->HALT SHALL occur when, at an unstalled edge, load is high with in == out (jump-to-self, the Hack end-of-program idiom) and clr is low.
REQ-020 While in HALT, load and inc SHALL be ignored and out SHALL hold.
REQ-021 HALT->RUN SHALL occur only via clr or rst_n; a clr in HALT also sets out to RESET_ADDR.
REQ-022 halted SHALL rise on the same edge that performs the self-jump; out is unchanged at that edge.

Reset
REQ-023 rst_n low SHALL immediately, independent of clk, force out = RESET_ADDR, halted = 0 and state = RUN.
REQ-024 rst_n deassertion SHALL be synchronised internally with a 2-flop release.
REQ-025 The first counting edge SHALL be the second rising edge after rst_n rises.
REQ-026 An async reset during any operation, including mid-HALT or while stalled, SHALL abort it with no residual state.

Configuration
REQ-027 Macro PROGRAM_COUNTER_HALT_DETECT_EN SHALL gate the halt feature.
REQ-028 With the macro defined, the RUN/HALT FSM and the halted output SHALL behave as specified in REQ-018 to REQ-022.
REQ-029 Without the macro, the FSM SHALL be omitted, halted SHALL be tied to 0, and a jump-to-self SHALL be an ordinary load.

Structure
REQ-030 A shared package SHALL hold the PC_WIDTH default (16), the PC_RESET_ADDR default (0) and the state enum pc_state_t {PC_RUN, PC_HALT}.
REQ-031 The next-address priority mux SHALL be a combinational sub-module named pc_next_sel.
REQ-032 pc_next_sel SHALL take in, out+1, RESET_ADDR, out and the clr/load/inc/stall/halted controls, and SHALL produce next.
REQ-033 The register, the reset synchroniser and the FSM SHALL remain in program_counter.

Verification
REQ-034 Reset, then inc=1 for 5 cycles -> out reads 0,1,2,3,4,5 (one step per edge).
REQ-035 out=0x0005, load=1, inc=1, in=0x1234 -> out=0x1234 after one edge; then clr=1, stall=1 -> out=0x0000 after one edge.
REQ-036 Load 0xFFFF, then inc -> out=0x0000 and halted=0.
REQ-037 With the macro defined: out=0x0010, load=1, in=0x0010 -> halted=1 and out=0x0010.
REQ-038 Continuing REQ-037: inc and load for 4 cycles -> out stays 0x0010 and halted stays 1; then clr -> out=0x0000, halted=0.
REQ-039 out=0x0042, stall=1 with inc=1 for 3 cycles -> out=0x0042 throughout.
REQ-040 Then pulse rst_n low mid-cycle -> out=0x0000 immediately, before the next clk edge.
REQ-041 Without the macro, rerun REQ-037 -> halted=0 and a subsequent inc gives out=0x0011.

Source files
------------

// File: rtl/program_counter_pkg.sv
// Shared definitions for the program counter slice: default width, default
// reset address and the RUN/HALT state encoding.
package program_counter_pkg;

   localparam int          PC_WIDTH      = 16;
   localparam logic [15:0] PC_RESET_ADDR = 16'h0000;

   typedef enum logic [0:0] {
      PC_RUN  = 1'b0,
      PC_HALT = 1'b1
   } pc_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-address select for the program counter.
// Priority: clr > (stall or halted hold) > load > inc > hold.
module pc_next_sel
   import program_counter_pkg::*;
#(
   parameter int WIDTH = PC_WIDTH
) (
   input  logic [WIDTH-1:0] in,
   input  logic [WIDTH-1:0] inc_addr,
   input  logic [WIDTH-1:0] reset_addr,
   input  logic [WIDTH-1:0] cur_addr,
   input  logic             clr,
   input  logic             load,
   input  logic             inc,
   input  logic             stall,
   input  logic             halted,
   output logic [WIDTH-1:0] next
);

   // Priority mux chain; clr wins even over stall and HALT.
   always_comb begin
      next = cur_addr;
      if (clr) begin
         next = reset_addr;
      end else if (stall || halted) begin
         next = cur_addr;
      end else if (load) begin
         next = in;
      end else if (inc) begin
         next = inc_addr;
      end else begin
         next = cur_addr;
      end
   end

endmodule

// File: rtl/program_counter.sv
// Program counter with load / increment / clear / stall and an optional
// jump-to-self halt detector.
// Optional feature macro: PROGRAM_COUNTER_HALT_DETECT_EN enables the RUN/HALT
// FSM; when undefined, halted is tied low and a jump-to-self is a plain load.
module program_counter
   import program_counter_pkg::*;
#(
   parameter int               WIDTH      = PC_WIDTH,
   parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(PC_RESET_ADDR)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   input  logic             load,
   input  logic             inc,
   input  logic             clr,
   input  logic             stall,
   output logic [WIDTH-1:0] out,
   output logic             halted
);

   logic [1:0]       rst_sync_r;
   logic             en_s;
   logic [WIDTH-1:0] out_r;
   logic [WIDTH-1:0] next_s;
   logic [WIDTH-1:0] inc_addr_s;
   logic             halted_s;

   // Reset release chain: asserts with rst_n, releases one stage per edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_r <= 2'b00;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b1};
      end
   end

   // Counting begins on the edge that releases the second stage, i.e. the
   // second rising edge after rst_n rises; the second stage keeps it sticky.
   assign en_s = rst_sync_r[0] | rst_sync_r[1];

   // Wrapping increment, no carry out.
   assign inc_addr_s = out_r + WIDTH'(1);

`ifdef PROGRAM_COUNTER_HALT_DETECT_EN
   pc_state_t state_r;
   pc_state_t state_next_s;
   logic      halted_r;

   // Next-state logic: an unstalled self-jump halts; only clr leaves HALT.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         PC_RUN: begin
            if (clr) begin
               state_next_s = PC_RUN;
            end else if (!stall && load && (in == out_r)) begin
               state_next_s = PC_HALT;
            end else begin
               state_next_s = PC_RUN;
            end
         end
         PC_HALT: begin
            if (clr) begin
               state_next_s = PC_RUN;
            end else begin
               state_next_s = PC_HALT;
            end
         end
         default: begin
            state_next_s = PC_RUN;
         end
      endcase
   end

   // State register and registered halted flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= PC_RUN;
         halted_r <= 1'b0;
      end else if (en_s) begin
         state_r  <= state_next_s;
         halted_r <= (state_next_s == PC_HALT);
      end else begin
         state_r  <= state_r;
         halted_r <= halted_r;
      end
   end

   assign halted_s = halted_r;
`else
   assign halted_s = 1'b0;
`endif

   pc_next_sel #(
      .WIDTH (WIDTH)
   ) u_next_sel (
      .in         (in),
      .inc_addr   (inc_addr_s),
      .reset_addr (RESET_ADDR),
      .cur_addr   (out_r),
      .clr        (clr),
      .load       (load),
      .inc        (inc),
      .stall      (stall),
      .halted     (halted_s),
      .next       (next_s)
   );

   // Address register; only updates once the reset release has completed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_r <= RESET_ADDR;
      end else if (en_s) begin
         out_r <= next_s;
      end else begin
         out_r <= out_r;
      end
   end

   assign out    = out_r;
   assign halted = halted_s;

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter (default parameters).
// Expectations follow PROGRAM_COUNTER_HALT_DETECT_EN when it is defined.
module tb_program_counter;

   logic        clk;
   logic        rst_n;
   logic [15:0] in;
   logic        load;
   logic        inc;
   logic        clr;
   logic        stall;
   logic [15:0] out;
   logic        halted;

   int checks;
   int errors;

   program_counter dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .in     (in),
      .load   (load),
      .inc    (inc),
      .clr    (clr),
      .stall  (stall),
      .out    (out),
      .halted (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One rising edge, then settle to the falling edge for sampling/driving.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      load  = 1'b0;
      inc   = 1'b0;
      clr   = 1'b0;
      stall = 1'b0;
      in    = 16'h0000;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      #1;
      checks++;
      if (out !== 16'h0000) begin
         errors++;
         $display("FAIL reset_out: got %h want 0000", out);
      end
      checks++;
      if (halted !== 1'b0) begin
         errors++;
         $display("FAIL reset_halted: got %b want 0", halted);
      end
      tick();
      tick();
      checks++;
      if (out !== 16'h0000) begin
         errors++;
         $display("FAIL reset_hold_clocked: got %h want 0000", out);
      end
   endtask

   task automatic test_count();
      logic [15:0] exp;
      // release mid-cycle with inc already high
      rst_n = 1'b1;
      inc   = 1'b1;
      tick();
      checks++;
      if (out !== 16'h0000) begin
         errors++;
         $display("FAIL count_first_edge: got %h want 0000", out);
      end
      exp = 16'h0000;
      for (int i = 0; i < 5; i++) begin
         tick();
         exp = exp + 16'h0001;
         checks++;
         if (out !== exp) begin
            errors++;
            $display("FAIL count_step%0d: got %h want %h", i, out, exp);
         end
      end
      inc = 1'b0;
   endtask

   task automatic test_load_clr();
      in   = 16'h1234;
      load = 1'b1;
      inc  = 1'b1;
      tick();
      checks++;
      if (out !== 16'h1234) begin
         errors++;
         $display("FAIL load_over_inc: got %h want 1234", out);
      end
      load  = 1'b0;
      inc   = 1'b0;
      clr   = 1'b1;
      stall = 1'b1;
      tick();
      checks++;
      if (out !== 16'h0000) begin
         errors++;
         $display("FAIL clr_over_stall: got %h want 0000", out);
      end
      in   = 16'h7777;
      load = 1'b1;
      stall = 1'b0;
      tick();
      checks++;
      if (out !== 16'h0000) begin
         errors++;
         $display("FAIL clr_over_load: got %h want 0000", out);
      end
      idle();
   endtask

   task automatic test_wrap();
      in   = 16'hFFFF;
      load = 1'b1;
      tick();
      checks++;
      if (out !== 16'hFFFF) begin
         errors++;
         $display("FAIL wrap_load: got %h want ffff", out);
      end
      load = 1'b0;
      inc  = 1'b1;
      tick();
      checks++;
      if (out !== 16'h0000) begin
         errors++;
         $display("FAIL wrap_inc: got %h want 0000", out);
      end
      checks++;
      if (halted !== 1'b0) begin
         errors++;
         $display("FAIL wrap_halted: got %b want 0", halted);
      end
      idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out !== 16'h0000) begin
            errors++;
            $display("FAIL idle_hold%0d: got %h want 0000", i, out);
         end
      end
   endtask

   task automatic test_self_jump();
      in   = 16'h0010;
      load = 1'b1;
      tick();
      checks++;
      if (out !== 16'h0010 || halted !== 1'b0) begin
         errors++;
         $display("FAIL jump_plain: got %h/%b want 0010/0", out, halted);
      end
      tick();
`ifdef PROGRAM_COUNTER_HALT_DETECT_EN
      checks++;
      if (out !== 16'h0010 || halted !== 1'b1) begin
         errors++;
         $display("FAIL self_jump_halt: got %h/%b want 0010/1", out, halted);
      end
      in  = 16'h0020;
      inc = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (out !== 16'h0010 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_hold%0d: got %h/%b want 0010/1", i, out, halted);
         end
      end
      load = 1'b0;
      inc  = 1'b0;
      clr  = 1'b1;
      tick();
      checks++;
      if (out !== 16'h0000 || halted !== 1'b0) begin
         errors++;
         $display("FAIL halt_clr: got %h/%b want 0000/0", out, halted);
      end
`else
      checks++;
      if (out !== 16'h0010 || halted !== 1'b0) begin
         errors++;
         $display("FAIL self_jump_plain: got %h/%b want 0010/0", out, halted);
      end
      load = 1'b0;
      inc  = 1'b1;
      tick();
      checks++;
      if (out !== 16'h0011 || halted !== 1'b0) begin
         errors++;
         $display("FAIL self_jump_then_inc: got %h/%b want 0011/0", out, halted);
      end
`endif
      idle();
   endtask

   task automatic test_stall();
      in   = 16'h0042;
      load = 1'b1;
      tick();
      checks++;
      if (out !== 16'h0042) begin
         errors++;
         $display("FAIL stall_setup: got %h want 0042", out);
      end
      load  = 1'b0;
      inc   = 1'b1;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out !== 16'h0042) begin
            errors++;
            $display("FAIL stall_hold%0d: got %h want 0042", i, out);
         end
      end
      // a stalled self-jump must neither move nor halt
      load = 1'b1;
      tick();
      checks++;
      if (out !== 16'h0042 || halted !== 1'b0) begin
         errors++;
         $display("FAIL stall_self_jump: got %h/%b want 0042/0", out, halted);
      end
      load = 1'b0;
   endtask

   task automatic test_async_reset();
      // stall and inc still high; pull rst_n mid-cycle
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out !== 16'h0000 || halted !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got %h/%b want 0000/0", out, halted);
      end
      @(negedge clk);
      idle();
      inc   = 1'b1;
      rst_n = 1'b1;
      tick();
      checks++;
      if (out !== 16'h0000) begin
         errors++;
         $display("FAIL rerelease_edge1: got %h want 0000", out);
      end
      tick();
      checks++;
      if (out !== 16'h0001) begin
         errors++;
         $display("FAIL rerelease_edge2: got %h want 0001", out);
      end
      idle();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      idle();
      @(negedge clk);
      test_reset();
      test_count();
      test_load_clr();
      test_wrap();
      test_self_jump();
      test_stall();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
